// File: rtl/msrv32_alu_pkg.sv
// +------------------------------------------------------------------+
// | msrv32_alu_pkg: shared width and RV32I ALU opcode encodings       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package msrv32_alu_pkg;

  localparam int XLEN = 32;

  // Opcode is {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

`default_nettype wire

// File: rtl/msrv32_alu_core.sv
// +------------------------------------------------------------------+
// | msrv32_alu_core: combinational RV32I ALU function                 |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module msrv32_alu_core
  import msrv32_alu_pkg::*;
(
  input  logic [XLEN-1:0] op_1,
  input  logic [XLEN-1:0] op_2,
  input  logic [3:0]      opcode,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = op_2[4:0];

  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD:  result = op_1 + op_2;
      ALU_SUB:  result = op_1 - op_2;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_1) < $signed(op_2))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_1 < op_2)};
      ALU_XOR:  result = op_1 ^ op_2;
      ALU_OR:   result = op_1 | op_2;
      ALU_AND:  result = op_1 & op_2;
      ALU_SLL:  result = op_1 << shamt;
      ALU_SRL:  result = op_1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(op_1) >>> shamt);
      // Unassigned encodings yield zero
      default:  result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/msrv32_alu.sv
// +------------------------------------------------------------------+
// | msrv32_alu: registered RV32I ALU; optional zero_out flag enabled  |
// | by macro MSRV32_ALU_ZERO_FLAG_EN.   Revision: 1.0                 |
// +------------------------------------------------------------------+
`default_nettype none

module msrv32_alu
  import msrv32_alu_pkg::*;
(
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic [XLEN-1:0] op_1_in,
  input  logic [XLEN-1:0] op_2_in,
  input  logic [3:0]      opcode_in,
  output logic [XLEN-1:0] result_out
`ifdef MSRV32_ALU_ZERO_FLAG_EN
  ,
  output logic            zero_out
`endif
);

  logic [XLEN-1:0] next_result;

  msrv32_alu_core u_core (
    .op_1   (op_1_in),
    .op_2   (op_2_in),
    .opcode (opcode_in),
    .result (next_result)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      result_out <= '0;
    end else begin
      result_out <= next_result;
    end
  end

`ifdef MSRV32_ALU_ZERO_FLAG_EN
  // Resets high to agree with the zeroed result register
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      zero_out <= 1'b1;
    end else begin
      zero_out <= (next_result == '0);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_msrv32_alu.sv
// +------------------------------------------------------------------+
// | tb_msrv32_alu: directed self-checking bench for msrv32_alu        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_msrv32_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] result_out;
`ifdef MSRV32_ALU_ZERO_FLAG_EN
  logic        zero_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_result = 32'h0;
  logic        model_on   = 1'b0;

  msrv32_alu dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .op_1_in              (a),
    .op_2_in              (b),
    .opcode_in            (op),
    .result_out           (result_out)
`ifdef MSRV32_ALU_ZERO_FLAG_EN
    ,
    .zero_out             (zero_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU written from the instruction semantics
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] code);
    logic [63:0] ext;
    int          sh;
    sh = int'(y % 32);
    case (code)
      4'b0000: return x + y;
      4'b1000: return x + (~y + 32'd1);
      4'b0010: return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'b0011: return (x < y) ? 32'd1 : 32'd0;
      4'b0100: return x ^ y;
      4'b0110: return x | y;
      4'b0111: return x & y;
      4'b0001: return x * (32'd1 << sh);
      4'b0101: return x / (32'd1 << sh);
      4'b1101: begin
        ext = {{32{x[31]}}, x} >> sh;
        return ext[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) exp_result = 32'h0;
    else     exp_result = model(a, b, op);
  end

  always @(posedge rst) exp_result = 32'h0;

  always @(negedge clk) begin
    if (model_on) begin
      check("model", result_out, exp_result);
`ifdef MSRV32_ALU_ZERO_FLAG_EN
      check("model_zero", {31'h0, zero_out}, {31'h0, exp_result == 32'h0});
`endif
    end
  end

  // Apply one vector, then check the literal result one edge later
  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic [3:0] code,
                      input logic [31:0] want, input string name);
    a  = x;
    b  = y;
    op = code;
    @(posedge clk);
    #1;
    check(name, result_out, want);
  endtask

  initial begin
    rst = 1'b1;
    a   = 32'h0;
    b   = 32'h0;
    op  = 4'b0000;
    #2;
    check("reset_result", result_out, 32'h0);
`ifdef MSRV32_ALU_ZERO_FLAG_EN
    check("reset_zero", {31'h0, zero_out}, 32'h1);
`endif
    @(posedge clk);
    #3;
    rst      = 1'b0;
    model_on = 1'b1;
    @(posedge clk);
    #1;

    step(32'd1, 32'd2, 4'b0000, 32'h0000_0003, "add_1_2");
    step(32'd1, 32'd2, 4'b1000, 32'hFFFF_FFFF, "sub_1_2");
    step(32'd1, 32'd2, 4'b0010, 32'h0000_0001, "slt_1_2");
    step(32'd1, 32'd2, 4'b0011, 32'h0000_0001, "sltu_1_2");
    step(32'd1, 32'd2, 4'b0111, 32'h0000_0000, "and_1_2");
    step(32'd1, 32'd2, 4'b0110, 32'h0000_0003, "or_1_2");
    step(32'd1, 32'd2, 4'b0100, 32'h0000_0003, "xor_1_2");
    step(32'd1, 32'd2, 4'b0001, 32'h0000_0004, "sll_1_2");
    step(32'd1, 32'd2, 4'b0101, 32'h0000_0000, "srl_1_2");
    step(32'd1, 32'd2, 4'b1101, 32'h0000_0000, "sra_1_2");

    step(32'h8000_0000, 32'h0000_0024, 4'b1101, 32'hF800_0000, "sra_shamt_mask");
    step(32'h8000_0000, 32'h0000_0024, 4'b0101, 32'h0800_0000, "srl_shamt_mask");
    step(32'h8000_0000, 32'h0000_0024, 4'b0001, 32'h0000_0000, "sll_shamt_mask");

    step(32'h8000_0000, 32'd1, 4'b0010, 32'h1, "slt_min");
    step(32'h8000_0000, 32'd1, 4'b0011, 32'h0, "sltu_min");
    step(32'hFFFF_FFFF, 32'd1, 4'b0010, 32'h1, "slt_neg1");
    step(32'hFFFF_FFFF, 32'd1, 4'b0011, 32'h0, "sltu_neg1");
    step(32'd1,         32'd1, 4'b0010, 32'h0, "slt_equal");

    step(32'hFFFF_FFFF, 32'd1, 4'b0000, 32'h0, "add_wrap");
`ifdef MSRV32_ALU_ZERO_FLAG_EN
    check("add_wrap_zero", {31'h0, zero_out}, 32'h1);
`endif
    step(32'h0, 32'd1, 4'b1000, 32'hFFFF_FFFF, "sub_wrap");
`ifdef MSRV32_ALU_ZERO_FLAG_EN
    check("sub_wrap_zero", {31'h0, zero_out}, 32'h0);
`endif

    step(32'd5, 32'd3, 4'b1001, 32'h0, "undef_1001");
    step(32'd5, 32'd3, 4'b1010, 32'h0, "undef_1010");
    step(32'd5, 32'd3, 4'b1111, 32'h0, "undef_1111");

    // Asynchronous reset arriving between edges
    step(32'd1, 32'd2, 4'b0000, 32'h3, "pre_reset_add");
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_now", result_out, 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold", result_out, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("reset_release_hold", result_out, 32'h0);
    @(posedge clk);
    #1;
    check("first_capture", result_out, 32'h3);

    step(32'hF0F0_1234, 32'h0FF0_00FF, 4'b0100, 32'hFF00_12CB, "xor_mixed");
    step(32'h7FFF_FFFF, 32'h8000_0000, 4'b0010, 32'h0, "slt_max_min");
    @(posedge clk);
    #1;
    model_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
